spi_master_multi: RTL and testbench

//  Parametrised SPI master: one shift engine serves NUM_SLAVES chip selects, DATA_W-bit frames,
//  all four CPOL/CPHA modes and a run-time SCLK divider. Next-generation master for the SPI

---
 rtl/spi_master_multi.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_multi                                             |
// | Description : SPI master, NUM_SLAVES chip selects, all CPOL/CPHA modes,     |
// |               run-time SCLK divider. Optional SPI_LSB_FIRST_EN adds the     |
// |               lsb_first port for run-time bit-order selection.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_master_multi #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_W     = 32,
   parameter int DVSR_W     = 4,
   localparam int SEL_W     = $clog2(NUM_SLAVES) | 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DVSR_W-1:0]     dvsr,
   input  logic [DATA_W-1:0]     tx_data,
`ifdef SPI_LSB_FIRST_EN
   input  logic                  lsb_first,
`endif
   output logic [DATA_W-1:0]     rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sel_err,
   output logic                  sclk,
   output logic                  mosi,
   input  logic [NUM_SLAVES-1:0] miso,
   output logic [NUM_SLAVES-1:0] cs_n
);

   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_P0    = 2'd1,
      ST_P1    = 2'd2,
      ST_TRAIL = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [DVSR_W-1:0]   r_cnt, w_cnt_nxt;
   logic [BIT_W-1:0]    r_bit, w_bit_nxt;
   logic [SEL_W-1:0]    r_sel, w_sel_nxt;
   logic                r_cpol, w_cpol_nxt;
   logic                r_cpha, w_cpha_nxt;
   logic [DVSR_W-1:0]   r_dvsr, w_dvsr_nxt;
   logic                r_lsb, w_lsb_nxt;
   logic [DATA_W-1:0]   r_txsh, w_txsh_nxt;
   logic [DATA_W-1:0]   r_rxsh, w_rxsh_nxt;
   logic [DATA_W-1:0]   r_rx, w_rx_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic                r_sclk, w_sclk_nxt;
   logic                r_mosi, w_mosi_nxt;
   logic [NUM_SLAVES-1:0] r_cs_n, w_cs_n_nxt;

   logic                w_lsb_in;
   logic                w_sel_ok;
   logic                w_tick;
   logic                w_last;
   logic                w_miso_bit;
   logic [NUM_SLAVES-1:0] w_cs_dec;
   logic                w_in_first;
   logic [DATA_W-1:0]   w_in_shifted;
   logic                w_tx_first;
   logic [DATA_W-1:0]   w_tx_shifted;
   logic [DATA_W-1:0]   w_rx_shifted;

`ifdef SPI_LSB_FIRST_EN
   assign w_lsb_in = lsb_first;
`else
   assign w_lsb_in = 1'b0;
`endif

   assign w_sel_ok = ({1'b0, slave_sel} < (SEL_W+1)'(NUM_SLAVES));
   assign w_tick   = (r_cnt == '0);
   assign w_last   = (r_bit == BIT_W'(DATA_W - 1));

   // The first bit goes straight from tx_data when it must appear on the accept edge.
   assign w_in_first   = w_lsb_in ? tx_data[0] : tx_data[DATA_W-1];
   assign w_in_shifted = w_lsb_in ? (tx_data >> 1) : (tx_data << 1);
   assign w_tx_first   = r_lsb ? r_txsh[0] : r_txsh[DATA_W-1];
   assign w_tx_shifted = r_lsb ? (r_txsh >> 1) : (r_txsh << 1);
   assign w_rx_shifted = r_lsb ? {w_miso_bit, r_rxsh[DATA_W-1:1]}
                               : {r_rxsh[DATA_W-2:0], w_miso_bit};

   always_comb begin
      w_miso_bit = 1'b0;
      w_cs_dec   = '1;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_sel == SEL_W'(i)) w_miso_bit = miso[i];
         if (slave_sel == SEL_W'(i)) w_cs_dec[i] = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_sel_nxt   = r_sel;
      w_cpol_nxt  = r_cpol;
      w_cpha_nxt  = r_cpha;
      w_dvsr_nxt  = r_dvsr;
      w_lsb_nxt   = r_lsb;
      w_txsh_nxt  = r_txsh;
      w_rxsh_nxt  = r_rxsh;
      w_rx_nxt    = r_rx;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_sclk_nxt  = r_sclk;
      w_mosi_nxt  = r_mosi;
      w_cs_n_nxt  = r_cs_n;

      case (r_state)
         ST_IDLE: begin
            w_sclk_nxt = cpol;
            w_mosi_nxt = 1'b0;
            w_busy_nxt = 1'b0;
            w_cs_n_nxt = '1;
            if (start) begin
               if (w_sel_ok) begin
                  w_state_nxt = ST_P0;
                  w_cnt_nxt   = dvsr;
                  w_bit_nxt   = '0;
                  w_sel_nxt   = slave_sel;
                  w_cpol_nxt  = cpol;
                  w_cpha_nxt  = cpha;
                  w_dvsr_nxt  = dvsr;
                  w_lsb_nxt   = w_lsb_in;
                  w_rxsh_nxt  = '0;
                  w_busy_nxt  = 1'b1;
                  w_cs_n_nxt  = w_cs_dec;
                  if (!cpha) begin
                     w_mosi_nxt = w_in_first;
                     w_txsh_nxt = w_in_shifted;
                  end else begin
                     w_txsh_nxt = tx_data;
                  end
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end

         ST_P0: begin
            if (w_tick) begin
               w_state_nxt = ST_P1;
               w_cnt_nxt   = r_dvsr;
               w_sclk_nxt  = ~r_cpol;
               if (!r_cpha) begin
                  w_rxsh_nxt = w_rx_shifted;
               end else begin
                  w_mosi_nxt = w_tx_first;
                  w_txsh_nxt = w_tx_shifted;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_P1: begin
            if (w_tick) begin
               w_cnt_nxt  = r_dvsr;
               w_sclk_nxt = r_cpol;
               if (r_cpha) w_rxsh_nxt = w_rx_shifted;
               if (w_last) begin
                  w_state_nxt = ST_TRAIL;
               end else begin
                  w_state_nxt = ST_P0;
                  w_bit_nxt   = r_bit + 1'b1;
                  if (!r_cpha) begin
                     w_mosi_nxt = w_tx_first;
                     w_txsh_nxt = w_tx_shifted;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_TRAIL: begin
            if (w_tick) begin
               w_state_nxt = ST_IDLE;
               w_cs_n_nxt  = '1;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_rx_nxt    = r_rxsh;
               w_mosi_nxt  = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sel   <= '0;
         r_cpol  <= 1'b0;
         r_cpha  <= 1'b0;
         r_dvsr  <= '0;
         r_lsb   <= 1'b0;
         r_txsh  <= '0;
         r_rxsh  <= '0;
         r_rx    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_sel   <= w_sel_nxt;
         r_cpol  <= w_cpol_nxt;
         r_cpha  <= w_cpha_nxt;
         r_dvsr  <= w_dvsr_nxt;
         r_lsb   <= w_lsb_nxt;
         r_txsh  <= w_txsh_nxt;
         r_rxsh  <= w_rxsh_nxt;
         r_rx    <= w_rx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_sclk  <= w_sclk_nxt;
         r_mosi  <= w_mosi_nxt;
         r_cs_n  <= w_cs_n_nxt;
      end
   end

   assign rx_data = r_rx;
   assign busy    = r_busy;
   assign done    = r_done;
   assign sel_err = r_err;
   assign sclk    = r_sclk;
   assign mosi    = r_mosi;
   assign cs_n    = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_multi                                          |
// | Description : Self-checking bench; behavioural SPI slaves against master.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] slave_sel;
   logic       cpol, cpha;
   logic [3:0] dvsr;
   logic [7:0] tx_data;
   logic       tb_lsb;
   logic [7:0] rx_data;
   logic       busy, done, sel_err, sclk, mosi;
   logic [3:0] miso;
   logic [3:0] cs_n;

   int n_checks = 0;
   int n_fail   = 0;

   spi_master_multi #(.NUM_SLAVES(4), .DATA_W(8), .DVSR_W(4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .slave_sel (slave_sel),
      .cpol      (cpol),
      .cpha      (cpha),
      .dvsr      (dvsr),
      .tx_data   (tx_data),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first (tb_lsb),
`endif
      .rx_data   (rx_data),
      .busy      (busy),
      .done      (done),
      .sel_err   (sel_err),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .cs_n      (cs_n)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural SPI slave model: acts on observed SCLK edges while its CS is low.
   logic [7:0] slave_val [4];
   logic [2:0] m_sel;
   logic       m_cpol, m_cpha, m_lsb;
   logic       s_active = 1'b0;
   int         s_sent, s_lead, s_trail;
   logic [7:0] s_cap;
   logic       s_prev;
   logic       s_cs_bad, s_idle_bad;
   int         a;

   function automatic logic [3:0] cs_exp(input logic [2:0] s);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << s[1:0]);
   endfunction

   task automatic slave_drive(input int idx);
      int pos;
      if (s_sent < 8) begin
         pos = m_lsb ? s_sent : 7 - s_sent;
         miso[idx] = slave_val[idx][pos];
         s_sent++;
      end
   endtask

   task automatic slave_capture();
      if (m_lsb) s_cap = {mosi, s_cap[7:1]};
      else       s_cap = {s_cap[6:0], mosi};
   endtask

   always @(negedge clk) begin
      a = -1;
      for (int i = 0; i < 4; i++) if (!cs_n[i] && a < 0) a = i;
      if (reset || a < 0) begin
         s_active = 1'b0;
      end else begin
         if (!s_active) begin
            s_active   = 1'b1;
            s_sent     = 0;
            s_lead     = 0;
            s_trail    = 0;
            s_cap      = 8'h00;
            s_cs_bad   = 1'b0;
            s_idle_bad = (sclk !== m_cpol);
            s_prev     = sclk;
            if (!m_cpha) slave_drive(a);
         end else if (sclk !== s_prev) begin
            if (sclk !== m_cpol) begin
               s_lead++;
               if (!m_cpha) slave_capture(); else slave_drive(a);
            end else begin
               s_trail++;
               if (!m_cpha) slave_drive(a); else slave_capture();
            end
            s_prev = sclk;
         end
         if (cs_n !== cs_exp(m_sel) || busy !== 1'b1) s_cs_bad = 1'b1;
      end
      for (int i = 0; i < 4; i++)
         if (!s_active || i != a) miso[i] = 1'($urandom);
   end

   logic [7:0] last_rx = 8'h00;

   task automatic wait_done(input bit poke, output int cyc, output int errs);
      bit seen;
      cyc  = 0;
      errs = 0;
      seen = 1'b0;
      while (!seen && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (sel_err) errs++;
         if (poke && cyc == 5) begin
            start     = 1'b1;
            slave_sel = 3'($urandom_range(0, 7));
            tx_data   = 8'($urandom);
         end
         if (poke && cyc == 9) start = 1'b0;
         if (done) seen = 1'b1;
      end
      if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic setup_frame(input logic [2:0] sel, input logic pol, input logic pha,
                              input logic [3:0] dv, input logic [7:0] tx,
                              input logic [7:0] sv, input logic lsb);
      m_sel = sel; m_cpol = pol; m_cpha = pha; m_lsb = lsb;
      slave_val[sel[1:0]] = sv;
      @(negedge clk);
      start = 1'b1; slave_sel = sel; cpol = pol; cpha = pha; dvsr = dv;
      tx_data = tx; tb_lsb = lsb;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [2:0] sel, input logic pol, input logic pha,
                            input logic [3:0] dv, input logic [7:0] tx,
                            input logic [7:0] sv, input logic lsb, input bit poke);
      int cyc, errs;
      check_eq("rx_hold", rx_data, last_rx);
      setup_frame(sel, pol, pha, dv, tx, sv, lsb);
      start = 1'b0;
      check_eq("busy_after_start", busy, 1'b1);
      // Scramble every latched input; the frame must not notice.
      tx_data = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
      dvsr = 4'($urandom); slave_sel = 3'($urandom_range(0, 3));
      tb_lsb = 1'($urandom);
      wait_done(poke, cyc, errs);
      check_eq("latency", cyc, 17 * (dv + 1));
      check_eq("rx_data", rx_data, sv);
      check_eq("mosi_bits", s_cap, tx);
      check_eq("lead_edges", s_lead, 8);
      check_eq("trail_edges", s_trail, 8);
      check_eq("cs_busy_in_frame", s_cs_bad, 1'b0);
      check_eq("sclk_idle_at_cs", s_idle_bad, 1'b0);
      check_eq("cs_n_at_done", cs_n, 4'hF);
      check_eq("busy_at_done", busy, 1'b0);
      if (poke) check_eq("sel_err_while_busy", errs, 0);
      last_rx = sv;
   endtask

   initial begin
      int cyc, errs, cnt;
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, errs, cnt;
      reset = 1'b1; start = 1'b0; slave_sel = 3'd0; cpol = 1'b0; cpha = 1'b0;
      dvsr = 4'd0; tx_data = 8'h00; tb_lsb = 1'b0;
      m_sel = 3'd0; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
      for (int i = 0; i < 4; i++) slave_val[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rx", rx_data, 8'h00);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_sel_err", sel_err, 1'b0);
      check_eq("rst_sclk", sclk, 1'b0);
      check_eq("rst_mosi", mosi, 1'b0);
      check_eq("rst_cs_n", cs_n, 4'hF);
      reset = 1'b0;

      // IDLE: sclk tracks the cpol input.
      @(negedge clk); cpol = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_sclk_cpol1", sclk, 1'b1);
      cpol = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_sclk_cpol0", sclk, 1'b0);

      run_frame(3'd2, 1'b0, 1'b0, 4'd0, 8'hA5, 8'h3C, 1'b0, 1'b0);
      run_frame(3'd2, 1'b0, 1'b1, 4'd3, 8'hA5, 8'h3C, 1'b0, 1'b0);
      run_frame(3'd2, 1'b1, 1'b0, 4'd3, 8'hA5, 8'h3C, 1'b0, 1'b0);
      run_frame(3'd2, 1'b1, 1'b1, 4'd3, 8'hA5, 8'h3C, 1'b0, 1'b0);
      run_frame(3'd0, 1'b0, 1'b1, 4'd15, 8'h5A, 8'hC3, 1'b0, 1'b0);

      // Rejected selects.
      for (int s = 5; s <= 7; s += 2) begin
         @(negedge clk); start = 1'b1; slave_sel = 3'(s);
         @(posedge clk); #1;
         start = 1'b0;
         check_eq("sel_err_pulse", sel_err, 1'b1);
         check_eq("sel_err_busy", busy, 1'b0);
         check_eq("sel_err_cs_n", cs_n, 4'hF);
         @(posedge clk); #1;
         check_eq("sel_err_one_cycle", sel_err, 1'b0);
         cnt = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (done || busy || cs_n !== 4'hF) cnt++;
         end
         check_eq("sel_err_no_frame", cnt, 0);
      end

      // Start pulsed while busy.
      run_frame(3'd1, 1'b0, 1'b0, 4'd1, 8'h96, 8'h69, 1'b0, 1'b1);

      // Randomised frames.
      for (int k = 0; k < 20; k++) begin
         logic lsb;
`ifdef SPI_LSB_FIRST_EN
         lsb = 1'($urandom);
`else
         lsb = 1'b0;
`endif
         run_frame(3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), lsb, 1'b0);
      end

      // Back-to-back frames with start held through done.
      setup_frame(3'd3, 1'b1, 1'b0, 4'd0, 8'hE1, 8'h1E, 1'b0);
      tx_data = 8'h7B;
      wait_done(1'b0, cyc, errs);
      check_eq("b2b_lat1", cyc, 17);
      check_eq("b2b_rx1", rx_data, 8'h1E);
      check_eq("b2b_mosi1", s_cap, 8'hE1);
      check_eq("b2b_gap_cs_n", cs_n, 4'hF);
      check_eq("b2b_gap_busy", busy, 1'b0);
      slave_val[3] = 8'hB4;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("b2b_restart_busy", busy, 1'b1);
      check_eq("b2b_restart_cs_n", cs_n, 4'b0111);
      wait_done(1'b0, cyc, errs);
      check_eq("b2b_lat2", cyc, 17);
      check_eq("b2b_rx2", rx_data, 8'hB4);
      check_eq("b2b_mosi2", s_cap, 8'h7B);
      last_rx = 8'hB4;

`ifdef SPI_LSB_FIRST_EN
      run_frame(3'd2, 1'b0, 1'b0, 4'd0, 8'h01, 8'h80, 1'b1, 1'b0);
      run_frame(3'd1, 1'b1, 1'b1, 4'd2, 8'hC5, 8'h3A, 1'b1, 1'b0);
`endif

      // Reset in the middle of bit 3.
      setup_frame(3'd1, 1'b0, 1'b0, 4'd1, 8'hFF, 8'h55, 1'b0);
      start = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_cs_n", cs_n, 4'hF);
      check_eq("midrst_sclk", sclk, 1'b0);
      check_eq("midrst_busy", busy, 1'b0);
      check_eq("midrst_rx", rx_data, 8'h00);
      check_eq("midrst_done", done, 1'b0);
      reset = 1'b0;
      cnt = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done || busy) cnt++;
      end
      check_eq("midrst_no_done", cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
